// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one fixed-latency hex_to_decimal converter among NUM_REQ requesters.
// Optional BCD_CONV_OVF_DETECT_EN: flags inputs above 9999 and saturates the result to 16'h9999.
module bcd_conv_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ID_W         = 3,
    parameter int unsigned CONV_LATENCY = 16
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [NUM_REQ-1:0]     REQ_VALID,
    input  logic [16*NUM_REQ-1:0]  REQ_DATA,
    output logic [NUM_REQ-1:0]     REQ_ACK,
    output logic                   CONV_VALID,
    output logic [15:0]            CONV_DATA,
    input  logic [15:0]            CONV_RESULT,
    output logic                   RESP_VALID,
    output logic [ID_W-1:0]        RESP_ID,
    output logic [15:0]            RESP_DATA,
    output logic                   RESP_OVF,
    output logic                   BUSY
);
    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = $clog2(CONV_LATENCY);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     ptr;
    logic [CNT_W-1:0]    cnt;

    logic                hi_found, lo_found;
    logic [ID_W-1:0]     hi_idx, lo_idx;
    logic [DATA_W-1:0]   hi_data, lo_data;
    logic                gnt_any;
    logic [ID_W-1:0]     gnt_idx;
    logic [DATA_W-1:0]   gnt_data;

`ifdef BCD_CONV_OVF_DETECT_EN
    logic                ovf_q;
`endif

    // Lowest set request at/above the pointer wins; otherwise lowest set request below it.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        hi_data  = '0;
        lo_data  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (REQ_VALID[i]) begin
                if (i >= int'(ptr)) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                    hi_data  = REQ_DATA[DATA_W*i +: DATA_W];
                end else begin
                    lo_found = 1'b1;
                    lo_idx   = ID_W'(i);
                    lo_data  = REQ_DATA[DATA_W*i +: DATA_W];
                end
            end
        end
        gnt_any  = hi_found | lo_found;
        gnt_idx  = hi_found ? hi_idx  : lo_idx;
        gnt_data = hi_found ? hi_data : lo_data;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_IDLE;
            ptr        <= '0;
            cnt        <= '0;
            REQ_ACK    <= '0;
            CONV_VALID <= 1'b0;
            CONV_DATA  <= '0;
            RESP_VALID <= 1'b0;
            RESP_ID    <= '0;
            RESP_DATA  <= '0;
            RESP_OVF   <= 1'b0;
            BUSY       <= 1'b0;
`ifdef BCD_CONV_OVF_DETECT_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            REQ_ACK    <= '0;
            CONV_VALID <= 1'b0;
            RESP_VALID <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (gnt_any) begin
                        CONV_DATA  <= gnt_data;
                        CONV_VALID <= 1'b1;
                        REQ_ACK    <= NUM_REQ'(1) << gnt_idx;
                        BUSY       <= 1'b1;
                        RESP_ID    <= gnt_idx;
                        ptr        <= (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
`ifdef BCD_CONV_OVF_DETECT_EN
                        ovf_q      <= (gnt_data > 16'd9999);
`endif
                        state      <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    cnt   <= CNT_W'(CONV_LATENCY - 1);
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
`ifdef BCD_CONV_OVF_DETECT_EN
                        RESP_OVF  <= ovf_q;
                        RESP_DATA <= ovf_q ? 16'h9999 : CONV_RESULT;
`else
                        RESP_OVF  <= 1'b0;
                        RESP_DATA <= CONV_RESULT;
`endif
                        RESP_VALID <= 1'b1;
                        BUSY       <= 1'b0;
                        state      <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Directed bench for bcd_conv_arbiter with a 16-cycle pipelined converter model.
module tb_bcd_conv_arbiter;
    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 3;
    localparam int unsigned LAT     = 16;

`ifdef BCD_CONV_OVF_DETECT_EN
    localparam logic [15:0] OVF_DATA = 16'h9999;
    localparam logic        OVF_FLAG = 1'b1;
`else
    localparam logic [15:0] OVF_DATA = 16'h5535;
    localparam logic        OVF_FLAG = 1'b0;
`endif

    logic                  CLK = 1'b0;
    logic                  RST;
    logic [NUM_REQ-1:0]    REQ_VALID;
    logic [16*NUM_REQ-1:0] REQ_DATA;
    logic [NUM_REQ-1:0]    REQ_ACK;
    logic                  CONV_VALID;
    logic [15:0]           CONV_DATA;
    logic [15:0]           CONV_RESULT;
    logic                  RESP_VALID;
    logic [ID_W-1:0]       RESP_ID;
    logic [15:0]           RESP_DATA;
    logic                  RESP_OVF;
    logic                  BUSY;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    bcd_conv_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .CONV_LATENCY(LAT)) dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_DATA(REQ_DATA), .REQ_ACK(REQ_ACK),
        .CONV_VALID(CONV_VALID), .CONV_DATA(CONV_DATA), .CONV_RESULT(CONV_RESULT),
        .RESP_VALID(RESP_VALID), .RESP_ID(RESP_ID), .RESP_DATA(RESP_DATA),
        .RESP_OVF(RESP_OVF), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [15:0] to_bcd(input logic [15:0] b);
        int v;
        v = int'(b) % 10000;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Converter model: result is valid exactly LAT edges after the edge that samples CONV_VALID.
    logic [15:0] pipe [LAT];
    always @(posedge CLK) begin
        pipe[0] <= CONV_VALID ? to_bcd(CONV_DATA) : 16'hEEEE;
        for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
    end
    assign CONV_RESULT = pipe[LAT-1];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({REQ_ACK, CONV_VALID, CONV_DATA, RESP_VALID, RESP_ID, RESP_DATA, RESP_OVF, BUSY});
    endfunction

    task automatic do_reset(input string tag);
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        check({tag, " outs_zero"}, all_outs(), 64'd0);
        RST = 1'b0;
    endtask

    task automatic set_req(input int id, input logic [15:0] d);
        REQ_DATA[16*id +: 16] = d;
        REQ_VALID[id] = 1'b1;
    endtask

    // Waits for a grant to requester id, drops its request on ACK, then follows it to its response.
    task automatic run_job(input string tag, input int id, input logic [15:0] din,
                           input logic [15:0] exp_data, input logic exp_ovf, output int gcyc);
        bit seen;
        int lat;
        int pulses;
        logic [NUM_REQ-1:0] exp_ack;
        gcyc = -1;
        seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge CLK);
            if (REQ_ACK != '0) seen = 1'b1;
        end
        check({tag, " ack_seen"}, 64'(seen), 64'd1);
        if (!seen) return;
        gcyc = cyc;
        exp_ack = NUM_REQ'(1) << id;
        check({tag, " ack"}, 64'(REQ_ACK), 64'(exp_ack));
        REQ_VALID[id] = 1'b0;
        check({tag, " conv_valid"}, 64'(CONV_VALID), 64'd1);
        check({tag, " conv_data"}, 64'(CONV_DATA), 64'(din));
        check({tag, " busy_on"}, 64'(BUSY), 64'd1);
        seen = 1'b0;
        lat = 0;
        pulses = 0;
        for (int n = 1; n <= 40 && !seen; n++) begin
            @(negedge CLK);
            if (CONV_VALID) pulses++;
            if (n == 1) check({tag, " ack_clear"}, 64'(REQ_ACK), 64'd0);
            if (RESP_VALID) begin
                seen = 1'b1;
                lat = n;
            end
        end
        check({tag, " resp_latency"}, 64'(lat), 64'd17);
        check({tag, " extra_conv_valid"}, 64'(pulses), 64'd0);
        check({tag, " resp_id"}, 64'(RESP_ID), 64'(id));
        check({tag, " resp_data"}, 64'(RESP_DATA), 64'(exp_data));
        check({tag, " resp_ovf"}, 64'(RESP_OVF), 64'(exp_ovf));
        check({tag, " busy_off"}, 64'(BUSY), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int g0, g1, g2, g3;
        int resp_cnt;
        RST = 1'b1;
        REQ_VALID = '0;
        REQ_DATA = '0;

        // Single request
        do_reset("rst0");
        set_req(0, 16'h04D2);
        run_job("single", 0, 16'h04D2, 16'h1234, 1'b0, g0);
        @(negedge CLK);
        check("single resp_clear", 64'(RESP_VALID), 64'd0);
        check("single data_hold", 64'(RESP_DATA), 64'h1234);
        check("single busy_low", 64'(BUSY), 64'd0);

        // All four requesters valid from reset
        set_req(0, 16'd1);
        set_req(1, 16'd22);
        set_req(2, 16'd333);
        set_req(3, 16'd4444);
        do_reset("rst1");
        run_job("all0", 0, 16'd1,    16'h0001, 1'b0, g0);
        run_job("all1", 1, 16'd22,   16'h0022, 1'b0, g1);
        run_job("all2", 2, 16'd333,  16'h0333, 1'b0, g2);
        run_job("all3", 3, 16'd4444, 16'h4444, 1'b0, g3);
        check("spacing01", 64'(g1 - g0), 64'd18);
        check("spacing12", 64'(g2 - g1), 64'd18);
        check("spacing23", 64'(g3 - g2), 64'd18);

        // Fairness plus boundaries: after requester 2, 3 beats 1
        set_req(2, 16'd0);
        run_job("zero", 2, 16'd0, 16'h0000, 1'b0, g0);
        set_req(1, 16'h270F);
        set_req(3, 16'hFFFF);
        run_job("fair_ovf", 3, 16'hFFFF, OVF_DATA, OVF_FLAG, g0);
        run_job("fair_max", 1, 16'h270F, 16'h9999, 1'b0, g1);

        // Reset 8 cycles into a conversion
        set_req(2, 16'd7);
        begin
            bit seen;
            seen = 1'b0;
            for (int n = 0; n < 60 && !seen; n++) begin
                @(negedge CLK);
                if (REQ_ACK != '0) seen = 1'b1;
            end
            check("abort ack_seen", 64'(REQ_ACK), 64'(4'b0100));
            REQ_VALID[2] = 1'b0;
        end
        repeat (7) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        check("abort outs_zero", all_outs(), 64'd0);
        RST = 1'b0;
        resp_cnt = 0;
        repeat (20) begin
            @(negedge CLK);
            if (RESP_VALID) resp_cnt++;
        end
        check("abort no_resp", 64'(resp_cnt), 64'd0);
        set_req(1, 16'd42);
        set_req(3, 16'd5);
        run_job("post_rst1", 1, 16'd42, 16'h0042, 1'b0, g0);
        run_job("post_rst3", 3, 16'd5,  16'h0005, 1'b0, g1);
        check("post_rst spacing", 64'(g1 - g0), 64'd18);

        repeat (3) @(negedge CLK);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Shares one hex_to_decimal converter among NUM_REQ requesters, e.g. four 7-segment display sources.
- Picks requesters round-robin and launches each conversion with a one-cycle CONV_VALID pulse.
- Waits a fixed converter latency, captures CONV_RESULT, and returns it with the requester ID.
- Sits between the display data sources and the converter instance in the 7segment_display top.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 3, width of RESP_ID. Must satisfy 2**ID_W >= NUM_REQ.
- CONV_LATENCY, 16, cycles from the converter clock edge that samples CONV_VALID to the edge where CONV_RESULT is sampled. Minimum 16.

Ports:
- CLK  in  1  single clock for the whole block.
- RST  in  1  synchronous, active-high reset.
- REQ_VALID  in  NUM_REQ  per-requester request. Requester holds it high until it sees its REQ_ACK bit.
- REQ_DATA  in  16*NUM_REQ  binary value per requester. Slice i = bits [16i+15:16i].
- REQ_ACK  out  NUM_REQ  one-cycle pulse: the request is accepted and its data is captured.
- CONV_VALID  out  1  drives converter INP_VALID.
- CONV_DATA  out  16  drives converter INP_HEX_DATA.
- CONV_RESULT  in  16  from converter OUT_DEC_DATA.
- RESP_VALID  out  1  one-cycle pulse: a result is available.
- RESP_ID  out  ID_W  index of the requester that owns the result.
- RESP_DATA  out  16  4-digit BCD result.
- RESP_OVF  out  1  overflow flag (see Optional Feature).
- BUSY  out  1  high from the grant edge until the RESP_VALID edge.

Behaviour:
- Reset (synchronous, RST=1 at a CLK edge):
  - All outputs go to 0 and state goes to IDLE.
  - Round-robin pointer goes to 0; the latency counter is cleared.
  - RST wins over every other event, including mid-WAIT. Any in-flight conversion is discarded with no RESP_VALID.
- States: IDLE, LAUNCH, WAIT.
- IDLE:
  - If any REQ_VALID bit is set at edge E0, grant g = first set bit searching upward from the pointer, wrapping at NUM_REQ.
  - Registered at E0: CONV_DATA <= slice g; CONV_VALID <= 1; REQ_ACK[g] <= 1; BUSY <= 1; RESP_ID <= g; pointer <= (g+1) mod NUM_REQ; state -> LAUNCH.
  - If no REQ_VALID bit is set, stay in IDLE with all pulse outputs at 0.
- LAUNCH (edge E1, the converter samples INP_VALID here):
  - CONV_VALID <= 0; REQ_ACK <= 0; counter <= CONV_LATENCY-1; state -> WAIT.
  - CONV_VALID is exactly one cycle wide. CONV_DATA holds its value until the next grant.
- WAIT:
  - Counter decrements each edge.
  - At the edge where counter==0 (edge E1+CONV_LATENCY): RESP_DATA <= CONV_RESULT; RESP_VALID <= 1; BUSY <= 0; state -> IDLE.
- RESP_VALID clears on the next edge. A new grant may occur on that same edge.
- Grant-to-grant spacing is CONV_LATENCY+2 cycles (18 at default).
- Requests that arrive while not in IDLE wait; they are not lost because the requester holds REQ_VALID.
- Requesters that arrive together are ordered by pointer, never by fixed priority.
- Protocol error: REQ_VALID dropped before REQ_ACK. Data was already captured at the grant edge and the conversion completes normally.
- RESP_ID and RESP_DATA hold their values between pulses.
- The converter uses an asynchronous reset. Its RST is driven from the same synchronised reset net as this block's RST.

Optional Feature:
- Macro: BCD_CONV_OVF_DETECT_EN.
- Defined:
  - At the grant edge, register ovf = (granted data > 16'd9999).
  - At capture, RESP_OVF <= ovf. If ovf, RESP_DATA <= 16'h9999 instead of CONV_RESULT (display saturates).
- Undefined:
  - RESP_OVF is held at 0.
  - RESP_DATA is always the raw CONV_RESULT, i.e. the value modulo 10000.

Test Plan:
- Single request: REQ_VALID[0]=1, slice0=16'h04D2 -> REQ_ACK[0] one cycle after the grant edge; exactly one CONV_VALID cycle; RESP_VALID 17 cycles after grant (E1+16) with RESP_DATA=16'h1234, RESP_ID=0; BUSY low afterward.
- All four requesters valid from reset, data 16'd1/16'd22/16'd333/16'd4444 -> responses 16'h0001, 16'h0022, 16'h0333, 16'h4444 with IDs 0,1,2,3 in that order, grants 18 cycles apart.
- Fairness: after serving requester 2, assert REQ_VALID[1] and [3] together -> requester 3 granted first, then requester 1.
- Boundaries: 16'd0 -> 16'h0000; 16'h270F -> 16'h9999 with RESP_OVF=0.
- Overflow: 16'hFFFF -> with macro: RESP_OVF=1, RESP_DATA=16'h9999; without macro: RESP_OVF=0, RESP_DATA=16'h5535.
- Reset mid-WAIT, 8 cycles after grant -> next edge all outputs 0 and pointer 0; no RESP_VALID for the aborted job; after release, requester 1 (data 16'd42) is served with RESP_DATA=16'h0042.
